countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- BCD countdown timer; the down-counting counterpart of the team's up-counting stopwatch.
- Loads a preset time, decrements one BCD count per prescaled tick while running, and signals expiry.
- Uses the same start/stop control style as the stopwatch so both blocks can share a front panel or button debouncer.
- Sits between the panel control logic and the display/alarm logic.

Parameters:
DIGITS, 2, number of BCD digits in the count (1..4)
PRESCALE, 10, ck cycles per count tick (>=1); PRESCALE=1 decrements every cycle

Ports:
ck  input  1  system clock, rising edge
res  input  1  asynchronous active-low reset
load  input  1  synchronous load of load_val (one-cycle strobe or level)
load_val  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0]
start  input  1  level; begin/resume counting
stop  input  1  level; pause counting
q  output  4*DIGITS  current BCD count
running  output  1  high while in RUN
done  output  1  one-cycle pulse when count reaches zero

Behaviour:
- Reset (res=0, asynchronous): state IDLE, q=0, prescaler=0, running=0, done=0, stored preset=0.
- States:
  - IDLE: after reset or load, not yet started.
  - RUN: counting.
  - PAUSE: stopped with a nonzero count.
  - EXPIRED: count reached zero.
- Per-cycle priority when not in reset: load > stop > start.
- load=1 from any state:
  - q <= load_val, with any digit >9 clamped to 9.
  - Preset register takes the same clamped value; prescaler=0; state -> IDLE.
  - start and stop are ignored that cycle.
- stop=1 in RUN: state -> PAUSE; prescaler holds its value. In other states stop has no effect.
- start=1 with stop=0 in IDLE or PAUSE:
  - q != 0: state -> RUN.
  - q == 0: state -> EXPIRED, no done pulse.
- start=1 in RUN or EXPIRED: no effect.
- start and stop both high: stop wins; RUN -> PAUSE; IDLE/PAUSE unchanged.
- RUN prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - A tick occurs on the cycle the prescaler equals PRESCALE-1.
  - First decrement occurs PRESCALE cycles after the RUN-entry edge.
- Tick in RUN: q decrements by one in BCD.
  - A digit at 0 borrows: it becomes 9 and the borrow propagates to the next digit.
  - Example: 10 -> 09, 100 -> 099.
- Tick that takes q from 1 to 0:
  - q=0; done=1 for exactly that following cycle; state -> EXPIRED; running=0 on the same edge.
- EXPIRED: q holds 0; there is no wrap to 99..9; only load or reset leaves this state.
- running is registered: 1 iff state==RUN.
- done is registered and otherwise 0.
- Reset asserted mid-count: all outputs return to reset values immediately. After release the block stays in IDLE with q=0.

Optional Feature:
- Macro name: AUTO_RELOAD_EN.
- Defined:
  - On the tick that reaches zero, done pulses as usual.
  - q <= stored preset, prescaler restarts at 0, state stays RUN, running stays 1.
  - If the stored preset is 0, the block enters EXPIRED as in the non-reload case.
- Not defined: behaviour exactly as described above; the preset register may be optimized away.

Test Plan:
- Reset and load. Stimulus: res low 1 cycle, then high, DIGITS=2, PRESCALE=4; load_val=8'h12, load 1 cycle, start=1. Required: q=8'h12, running=1 on the edge after start; q=8'h11 after 4 cycles; q=8'h10, then 8'h09 at 4-cycle intervals.
- Pause and resume. Stimulus: stop=1 for 10 cycles mid-count, then start=1. Required: q frozen and running=0 during stop; the next decrement lands on the remaining prescaler count, not a full 4 cycles.
- Expiry. Stimulus: load 8'h02, start. Required: q goes 02 -> 01 -> 00; done is high exactly one cycle, coincident with q=00; state EXPIRED; q stays 00 for 20 more cycles with start held high.
- Clamp and priority. Stimulus: load_val=8'hA5 with load, start and stop all high in the same cycle. Required: q=8'h95, state IDLE, running=0.
- Zero start and async reset. Stimulus: load 8'h00 then start, so done never pulses; then load 8'h50, run, and assert res low between clock edges. Required: q=0, running=0, done=0 immediately, before the next ck edge.
- AUTO_RELOAD_EN. Stimulus: load 8'h03, start, run 20 ticks. Required: done pulses every 3 ticks and q cycles 03, 02, 01, 03 (with a done pulse at each reload), 02, ...

Source files
------------

// File: rtl/countdown_timer_if.sv
// Panel-side bundle for countdown_timer: load/start/stop controls in, BCD count and status out.
// The master drives the controls; the timer (slave) drives q, running and done.
interface countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  stop;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;

  modport master (output load, load_val, start, stop, input q, running, done);
  modport slave  (input load, load_val, start, stop, output q, running, done);
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer: all outputs registered (1-cycle), controls are levels with no backpressure.
// Optional AUTO_RELOAD_EN: on expiry reload the stored preset and keep running.
module countdown_timer #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 10
) (
  input  logic             ck,
  input  logic             res,
  countdown_timer_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
`ifdef AUTO_RELOAD_EN
  logic [W-1:0]  preset_q, preset_d;
`endif

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decrement with borrow: a zero digit wraps to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    preset_d = preset_q;
`endif
    if (bus.load) begin
      q_d      = bcd_clamp(bus.load_val);
`ifdef AUTO_RELOAD_EN
      preset_d = bcd_clamp(bus.load_val);
`endif
      pre_d    = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (bus.start && !bus.stop) state_d = (q_q == '0) ? EXPIRED : RUN;
        end
        RUN: begin
          // Prescaler freezes on stop so a resume finishes the partial tick.
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            q_d   = bcd_dec(q_q);
            if (q_d == '0) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (preset_q != '0) q_d = preset_q;
              else                state_d = EXPIRED;
`else
              state_d = EXPIRED;
`endif
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      q_q       <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
      preset_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef AUTO_RELOAD_EN
      preset_q  <= preset_d;
`endif
    end
  end

  assign bus.q       = q_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with DIGITS=2, PRESCALE=4; expected values are hand-computed.
module tb_countdown_timer;
  logic ck;
  logic res;
  int   n_tests;
  int   n_fail;

  countdown_timer_if #(.DIGITS(2)) bus_if ();

  countdown_timer #(.DIGITS(2), .PRESCALE(4)) dut (
    .ck  (ck),
    .res (res),
    .bus (bus_if)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus_if.load     = 1'b1;
    bus_if.load_val = v;
    step(1);
    bus_if.load     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    res             = 1'b0;
    bus_if.load     = 1'b0;
    bus_if.load_val = 8'h00;
    bus_if.start    = 1'b0;
    bus_if.stop     = 1'b0;
    step(1);
    check("rst_q", {8'h0, bus_if.q}, 16'h0000);
    check("rst_running", {15'h0, bus_if.running}, 16'h0);
    check("rst_done", {15'h0, bus_if.done}, 16'h0);
    res = 1'b1;

    // Load and count down at 4-cycle intervals
    do_load(8'h12);
    check("load_q", {8'h0, bus_if.q}, 16'h0012);
    check("load_idle", {15'h0, bus_if.running}, 16'h0);
    bus_if.start = 1'b1;
    step(1);
    check("run_q", {8'h0, bus_if.q}, 16'h0012);
    check("run_running", {15'h0, bus_if.running}, 16'h1);
    bus_if.start = 1'b0;
    step(3);
    check("pre_hold_q", {8'h0, bus_if.q}, 16'h0012);
    step(1);
    check("dec1_q", {8'h0, bus_if.q}, 16'h0011);
    step(4);
    check("dec2_q", {8'h0, bus_if.q}, 16'h0010);
    step(4);
    check("borrow_q", {8'h0, bus_if.q}, 16'h0009);

    // Pause with prescaler at 2, then resume: decrement 2 edges after the resume edge
    step(2);
    bus_if.stop = 1'b1;
    step(1);
    check("pause_running", {15'h0, bus_if.running}, 16'h0);
    step(9);
    check("pause_q", {8'h0, bus_if.q}, 16'h0009);
    check("pause_running2", {15'h0, bus_if.running}, 16'h0);
    bus_if.stop  = 1'b0;
    bus_if.start = 1'b1;
    step(1);
    check("resume_running", {15'h0, bus_if.running}, 16'h1);
    check("resume_q", {8'h0, bus_if.q}, 16'h0009);
    bus_if.start = 1'b0;
    step(1);
    check("resume_hold_q", {8'h0, bus_if.q}, 16'h0009);
    step(1);
    check("resume_dec_q", {8'h0, bus_if.q}, 16'h0008);

`ifdef AUTO_RELOAD_EN
    // Auto reload: 03,02,01 then back to 03 with a done pulse
    begin
      logic [7:0] exp_q;
      do_load(8'h03);
      bus_if.start = 1'b1;
      step(1);
      bus_if.start = 1'b0;
      exp_q = 8'h03;
      for (int k = 0; k < 20; k++) begin
        logic exp_done;
        step(4);
        if (exp_q == 8'h01) begin
          exp_q    = 8'h03;
          exp_done = 1'b1;
        end else begin
          exp_q    = exp_q - 8'h01;
          exp_done = 1'b0;
        end
        check("reload_q", {8'h0, bus_if.q}, {8'h0, exp_q});
        check("reload_done", {15'h0, bus_if.done}, {15'h0, exp_done});
        check("reload_running", {15'h0, bus_if.running}, 16'h1);
      end
    end
`else
    // Expiry from 02
    do_load(8'h02);
    bus_if.start = 1'b1;
    step(1);
    check("exp_start_q", {8'h0, bus_if.q}, 16'h0002);
    step(4);
    check("exp_01_q", {8'h0, bus_if.q}, 16'h0001);
    step(3);
    check("exp_pre_done", {15'h0, bus_if.done}, 16'h0);
    step(1);
    check("exp_00_q", {8'h0, bus_if.q}, 16'h0000);
    check("exp_done", {15'h0, bus_if.done}, 16'h1);
    check("exp_running", {15'h0, bus_if.running}, 16'h0);
    step(1);
    check("exp_done_clr", {15'h0, bus_if.done}, 16'h0);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("exp_hold_q", {8'h0, bus_if.q}, 16'h0000);
      check("exp_hold_done", {15'h0, bus_if.done}, 16'h0);
      check("exp_hold_running", {15'h0, bus_if.running}, 16'h0);
    end
    bus_if.start = 1'b0;
`endif

    // Clamp and priority: load beats stop and start
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    do_load(8'hA5);
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    check("clamp_q", {8'h0, bus_if.q}, 16'h0095);
    check("clamp_running", {15'h0, bus_if.running}, 16'h0);
    step(2);
    check("clamp_idle_q", {8'h0, bus_if.q}, 16'h0095);
    check("clamp_idle_running", {15'h0, bus_if.running}, 16'h0);

    // Zero start: goes straight to expired, never pulses done
    do_load(8'h00);
    bus_if.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("zero_done", {15'h0, bus_if.done}, 16'h0);
      check("zero_running", {15'h0, bus_if.running}, 16'h0);
    end
    bus_if.start = 1'b0;

    // Asynchronous reset mid-count
    do_load(8'h50);
    bus_if.start = 1'b1;
    step(1);
    bus_if.start = 1'b0;
    check("ar_running", {15'h0, bus_if.running}, 16'h1);
    step(4);
    check("ar_q", {8'h0, bus_if.q}, 16'h0049);
    #2;
    res = 1'b0;
    #1;
    check("ar_async_q", {8'h0, bus_if.q}, 16'h0000);
    check("ar_async_running", {15'h0, bus_if.running}, 16'h0);
    check("ar_async_done", {15'h0, bus_if.done}, 16'h0);
    #2;
    res = 1'b1;
    step(3);
    check("ar_post_q", {8'h0, bus_if.q}, 16'h0000);
    check("ar_post_running", {15'h0, bus_if.running}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
